// File: rtl/uart_tx_cfg_if.sv
// Producer-to-transmitter word handshake. A word moves on a rising clock edge
// where tx_valid and tx_ready are both high; the transmitter samples tx_data,
// parity_mode and two_stop only then, and they are don't-care otherwise.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic [1:0]           parity_mode;
  logic                 two_stop;

  modport master (
    output tx_valid,
    output tx_data,
    output parity_mode,
    output two_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  parity_mode,
    input  two_stop,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start, DATA_BITS data bits LSB first, optional parity and
// 1 or 2 stop bits. Each bit lasts OVERSAMPLE pulses of the external b_tick.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         b_tick,
  uart_tx_cfg_if.slave bus,
  output logic         tx_busy,
  output logic         tx_done,
  output logic         tx,
  output logic [2:0]   o_dbg_state
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_two_stop, w_two_nxt;
  logic                 r_stop_cnt, w_stop_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_accept;
  logic                 w_bit_end;

  assign bus.tx_ready = (r_state == S_IDLE);
  assign w_accept     = bus.tx_valid & bus.tx_ready;
  assign w_bit_end    = b_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done      = r_done;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_par_en   <= w_par_en_nxt;
      r_two_stop <= w_two_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // tx is registered from the next-state decision so it only moves at bit ends.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_par_en_nxt = r_par_en;
    w_two_nxt    = r_two_stop;
    w_stop_nxt   = r_stop_cnt;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    if (r_state != S_IDLE && b_tick)
      w_tick_nxt = w_bit_end ? '0 : r_tick_cnt + TW'(1);

    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = bus.tx_data;
          w_par_nxt    = (bus.parity_mode == 2'b10) ? ~^bus.tx_data : ^bus.tx_data;
          w_par_en_nxt = ^bus.parity_mode;
          w_two_nxt    = bus.two_stop;
          w_tick_nxt   = '0;
          w_bit_nxt    = '0;
          w_stop_nxt   = 1'b0;
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit_cnt + BW'(1);
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            w_tx_nxt    = r_par_en ? r_par : 1'b1;
          end else begin
            w_tx_nxt = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && !r_stop_cnt) begin
            w_stop_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frames are captured one level per consumed b_tick and
// compared with a frame built directly from the framing rules.
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_tick_a = 1'b0;
  logic b_tick_b = 1'b0;
  logic tx_busy_a, tx_done_a, tx_a;
  logic tx_busy_b, tx_done_b, tx_b;
  logic [2:0] dbg_a, dbg_b;

  uart_tx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_tx_cfg_if #(.DATA_BITS(7)) ifb ();

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst(rst), .b_tick(b_tick_a), .bus(ifa),
    .tx_busy(tx_busy_a), .tx_done(tx_done_a), .tx(tx_a), .o_dbg_state(dbg_a)
  );
  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
    .clk(clk), .rst(rst), .b_tick(b_tick_b), .bus(ifb),
    .tx_busy(tx_busy_b), .tx_done(tx_done_b), .tx(tx_b), .o_dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int tick_period = 1;  // 0 = random b_tick gaps
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  typedef struct {
    logic [7:0] word;
    logic [1:0] mode;
    logic       two;
    int         exp_len;
    logic       exp_par;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic run_cycle();
    logic bt;
    @(negedge clk);
    cyc++;
    if (tick_period == 0) bt = ($urandom_range(0, 1) == 1);
    else bt = ((cyc % tick_period) == 0);
    b_tick_a = bt;
    b_tick_b = bt;
  endtask

  // Expected line levels, one entry per b_tick of the frame.
  task automatic model_frame(input logic [8:0] word, input int nbits, input logic [1:0] mode,
                             input logic two, input int os);
    logic [0:0] bits[$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (mode == 2'd1) bits.push_back(1'((ones % 2)));
    else if (mode == 2'd2) bits.push_back(1'((1 - ones % 2)));
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[i]) repeat (os) exp_q.push_back(bits[i]);
  endtask

  task automatic compare_q(output int errs);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    errs = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                         : exp_q.size() - got_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) errs++;
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, got no tx_done, required tx_done", name);
  endtask

  task automatic frame_a(input logic [7:0] word, input logic [1:0] mode, input logic two,
                         output int cycles, output int ready_err);
    int guard;
    got_q.delete();
    cycles = 0;
    ready_err = 0;
    ifa.tx_data = word;
    ifa.parity_mode = mode;
    ifa.two_stop = two;
    ifa.tx_valid = 1'b1;
    guard = 0;
    while (!ifa.tx_ready && guard < 5000) begin run_cycle(); guard++; end
    run_cycle();
    ifa.tx_valid = 1'b0;
    guard = 0;
    while (!tx_done_a && guard < 20000) begin
      if (tx_busy_a) begin
        cycles++;
        if (b_tick_a) got_q.push_back(tx_a);
        if (ifa.tx_ready) ready_err++;
      end
      ifa.tx_data = 8'($urandom);
      ifa.parity_mode = 2'($urandom);
      ifa.two_stop = 1'($urandom);
      run_cycle();
      guard++;
    end
    if (guard >= 20000) timeout("frame_a");
    run_cycle();
    check("done_one_cycle", {31'd0, tx_done_a}, 32'd0);
  endtask

  task automatic frame_b(input logic [6:0] word, input logic [1:0] mode, input logic two);
    int guard;
    got_q.delete();
    ifb.tx_data = word;
    ifb.parity_mode = mode;
    ifb.two_stop = two;
    ifb.tx_valid = 1'b1;
    guard = 0;
    while (!ifb.tx_ready && guard < 5000) begin run_cycle(); guard++; end
    run_cycle();
    ifb.tx_valid = 1'b0;
    guard = 0;
    while (!tx_done_b && guard < 20000) begin
      if (tx_busy_b && b_tick_b) got_q.push_back(tx_b);
      ifb.tx_data = 7'($urandom);
      run_cycle();
      guard++;
    end
    if (guard >= 20000) timeout("frame_b");
  endtask

  initial begin
    int cycles, ready_err, errs, guard, dones, idle_cnt, idle_bad, plen;
    logic [7:0] w;
    logic [1:0] m;
    logic t;
    logic [0:0] tmp_q[$];

    vecs[0] = '{8'h55, 2'd0, 1'b0, 160, 1'b0};
    vecs[1] = '{8'h07, 2'd1, 1'b0, 176, 1'b1};
    vecs[2] = '{8'h07, 2'd2, 1'b0, 176, 1'b0};
    vecs[3] = '{8'hA3, 2'd1, 1'b1, 192, 1'b0};
    vecs[4] = '{8'h3C, 2'd3, 1'b0, 160, 1'b0};
    vecs[5] = '{8'hC9, 2'd2, 1'b1, 192, 1'b1};

    ifa.tx_valid = 1'b0; ifa.tx_data = '0; ifa.parity_mode = '0; ifa.two_stop = 1'b0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0; ifb.parity_mode = '0; ifb.two_stop = 1'b0;
    rst = 1'b1;
    repeat (3) run_cycle();
    rst = 1'b0;
    run_cycle();
    check("reset_tx", {31'd0, tx_a}, 32'd1);
    check("reset_busy", {31'd0, tx_busy_a}, 32'd0);
    check("reset_done", {31'd0, tx_done_a}, 32'd0);
    check("reset_ready", {31'd0, ifa.tx_ready}, 32'd1);
    check("reset_tx_b", {31'd0, tx_b}, 32'd1);

    // Table of directed frames, b_tick every cycle.
    tick_period = 1;
    foreach (vecs[i]) begin
      frame_a(vecs[i].word, vecs[i].mode, vecs[i].two, cycles, ready_err);
      model_frame({1'b0, vecs[i].word}, 8, vecs[i].mode, vecs[i].two, 16);
      compare_q(errs);
      check($sformatf("vec%0d_bits", i), errs, 0);
      check($sformatf("vec%0d_ticks", i), got_q.size(), vecs[i].exp_len);
      check($sformatf("vec%0d_busy_cycles", i), cycles, vecs[i].exp_len);
      check($sformatf("vec%0d_ready_low", i), ready_err, 0);
      if (vecs[i].mode == 2'd1 || vecs[i].mode == 2'd2) begin
        if (got_q.size() > 144) check($sformatf("vec%0d_parity", i), {31'd0, got_q[144]},
                                      {31'd0, vecs[i].exp_par});
        else check($sformatf("vec%0d_parity_present", i), got_q.size(), 145);
      end
    end

    // Back-to-back: tx_valid held high, second word accepted in the tx_done cycle.
    ifa.tx_data = 8'h01; ifa.parity_mode = 2'd0; ifa.two_stop = 1'b0; ifa.tx_valid = 1'b1;
    guard = 0;
    while (!ifa.tx_ready && guard < 5000) begin run_cycle(); guard++; end
    run_cycle();
    ifa.tx_data = 8'h80;
    got_q.delete();
    dones = 0; idle_cnt = 0; idle_bad = 0; guard = 0;
    while (dones < 2 && guard < 20000) begin
      if (tx_busy_a && b_tick_a) got_q.push_back(tx_a);
      if (!tx_busy_a && !(tx_done_a && dones == 1)) begin
        idle_cnt++;
        if (tx_a !== 1'b1) idle_bad++;
      end
      if (tx_done_a) dones++;
      run_cycle();
      if (dones == 1 && tx_busy_a) ifa.tx_valid = 1'b0;
      guard++;
    end
    ifa.tx_valid = 1'b0;
    if (guard >= 20000) timeout("back_to_back");
    model_frame(9'h001, 8, 2'd0, 1'b0, 16);
    tmp_q = exp_q;
    model_frame(9'h080, 8, 2'd0, 1'b0, 16);
    exp_q = {tmp_q, exp_q};
    compare_q(errs);
    check("b2b_bits", errs, 0);
    check("b2b_idle_cycles", idle_cnt, 1);
    check("b2b_idle_tx_high", idle_bad, 0);
    run_cycle();

    // Reset in the middle of data bit 3 with b_tick every 5th cycle.
    tick_period = 5;
    ifa.tx_data = 8'h5A; ifa.parity_mode = 2'd1; ifa.two_stop = 1'b0; ifa.tx_valid = 1'b1;
    guard = 0;
    while (!ifa.tx_ready && guard < 5000) begin run_cycle(); guard++; end
    run_cycle();
    ifa.tx_valid = 1'b0;
    got_q.delete();
    guard = 0;
    while (got_q.size() < 72 && guard < 5000) begin
      if (tx_busy_a && b_tick_a) got_q.push_back(tx_a);
      if (got_q.size() < 72) run_cycle();
      guard++;
    end
    check("pre_reset_busy", {31'd0, tx_busy_a}, 32'd1);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    check("mid_reset_tx", {31'd0, tx_a}, 32'd1);
    check("mid_reset_busy", {31'd0, tx_busy_a}, 32'd0);
    check("mid_reset_ready", {31'd0, ifa.tx_ready}, 32'd1);
    check("mid_reset_done", {31'd0, tx_done_a}, 32'd0);
    dones = 0;
    repeat (200) begin
      run_cycle();
      if (tx_done_a || tx_busy_a) dones++;
    end
    check("post_reset_quiet", dones, 0);
    frame_a(8'hFF, 2'd0, 1'b0, cycles, ready_err);
    model_frame(9'h0FF, 8, 2'd0, 1'b0, 16);
    compare_q(errs);
    check("post_reset_ff_bits", errs, 0);

    // Narrow configuration: 7 data bits, 8 ticks per bit, odd parity.
    tick_period = 1;
    frame_b(7'h41, 2'd2, 1'b0);
    model_frame(9'h041, 7, 2'd2, 1'b0, 8);
    compare_q(errs);
    check("cfg7_bits", errs, 0);
    check("cfg7_ticks", got_q.size(), 80);
    if (got_q.size() > 64) check("cfg7_parity", {31'd0, got_q[64]}, 32'd1);
    else check("cfg7_parity_present", got_q.size(), 65);

    // Random frames with random b_tick spacing.
    for (int k = 0; k < 10; k++) begin
      tick_period = $urandom_range(0, 3);
      w = 8'($urandom);
      m = 2'($urandom_range(0, 3));
      t = 1'($urandom_range(0, 1));
      frame_a(w, m, t, cycles, ready_err);
      model_frame({1'b0, w}, 8, m, t, 16);
      compare_q(errs);
      plen = 1 + 8 + ((m == 2'd1 || m == 2'd2) ? 1 : 0) + (t ? 2 : 1);
      check($sformatf("rand%0d_bits w=%0h m=%0d s=%0d", k, w, m, t), errs, 0);
      check($sformatf("rand%0d_ticks", k), got_q.size(), 16 * plen);
      check($sformatf("rand%0d_ready_low", k), ready_err, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
